// File: rtl/gate_vector_seq_if.sv
// Stimulus/result bundle between the vector sequencer and its environment.
// The gate under test closes the loop from vec back to dut_o.
interface gate_vector_seq_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            dut_o;
    logic [N_IN-1:0] vec;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;

    modport master (
        input  start, dut_o,
        output vec, busy, done, pass, err_cnt, first_err_vec
    );

    modport slave (
        output start, dut_o,
        input  vec, busy, done, pass, err_cnt, first_err_vec
    );
endinterface

// File: rtl/gate_vector_seq.sv
// Exhaustive stimulus sequencer for a small combinational gate: walks every
// input vector, compares the gate output with a truth table, counts mismatches.
module gate_vector_seq #(
    parameter int                 N_IN        = 3,
    parameter int                 HOLD_CYCLES = 100,
    parameter logic [2**N_IN-1:0] TRUTH_TABLE = 8'b1000_0000
) (
    input logic              clk,
    input logic              rst_n,
    gate_vector_seq_if.master io
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic            mism;
    logic [N_IN:0]   err_upd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        mism    = io.dut_o != TRUTH_TABLE[vec_q];
        err_upd = err_q + (N_IN + 1)'(mism);

        unique case (state_q)
            IDLE, DONE: begin
                if (io.start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    hold_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            DRIVE: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HOLD_LAST) begin
                    err_d = err_upd;
                    // err_q still zero means this is the run's first miss
                    if (mism && err_q == '0)
                        first_d = vec_q;
                    if (vec_q == VEC_MAX) begin
                        state_d = DONE;
                        hold_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = err_upd == '0;
                    end else begin
                        vec_d  = vec_q + N_IN'(1);
                        hold_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.vec           = vec_q;
    assign io.busy          = busy_q;
    assign io.done          = done_q;
    assign io.pass          = pass_q;
    assign io.err_cnt       = err_q;
    assign io.first_err_vec = first_q;
endmodule

// File: tb/tb_gate_vector_seq.sv
// Directed bench for gate_vector_seq: N_IN=3, HOLD_CYCLES=4, AND gate model
// with stuck-at-0 / stuck-at-1 fault modes behind vec.
module tb_gate_vector_seq;
    localparam int N_IN = 3;
    localparam int HC   = 4;
    localparam int NV   = 8;

    logic clk;
    logic rst_n;
    int   mode;
    int   total;
    int   passed;

    gate_vector_seq_if #(.N_IN(N_IN)) io ();

    gate_vector_seq #(
        .N_IN        (N_IN),
        .HOLD_CYCLES (HC),
        .TRUTH_TABLE (8'b1000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: AND gate, 1: stuck at 0, 2: stuck at 1
    always_comb begin
        io.dut_o = 1'b0;
        if (mode == 0)
            io.dut_o = &io.vec;
        else if (mode == 2)
            io.dut_o = 1'b1;
    end

    task automatic pulse_start();
        @(negedge clk);
        io.start = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
    endtask

    // Follows a run from just after its start edge; returns the edge at
    // which done rose (0 if never) and whether vec/busy tracked the schedule.
    task automatic wait_done(input int inject, output int done_edge,
                             output bit seq_ok);
        int exp_vec;
        done_edge = 0;
        seq_ok    = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == inject + 1)
                io.start = 1'b0;
            if (e == inject)
                io.start = 1'b1;
            exp_vec = (e < NV * HC) ? e / HC : NV - 1;
            if (io.vec !== exp_vec[N_IN-1:0])
                seq_ok = 1'b0;
            if (io.done === 1'b1) begin
                if (io.busy !== 1'b0)
                    seq_ok = 1'b0;
                done_edge = e;
                break;
            end
            if (io.busy !== 1'b1)
                seq_ok = 1'b0;
        end
        io.start = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({io.vec, io.busy, io.done, io.pass, io.err_cnt, io.first_err_vec}
            !== '0)
            $display("FAIL reset_outputs got vec=%0d busy=%b done=%b pass=%b err=%0d first=%0d want all 0",
                     io.vec, io.busy, io.done, io.pass, io.err_cnt,
                     io.first_err_vec);
        else
            passed++;
    endtask

    task automatic test_and_run();
        int de;
        bit ok;
        mode = 0;
        pulse_start();
        total++;
        if (io.busy !== 1'b1 || io.vec !== 3'd0)
            $display("FAIL start_edge got busy=%b vec=%0d want busy=1 vec=0",
                     io.busy, io.vec);
        else
            passed++;
        wait_done(0, de, ok);
        total++;
        if (de !== 32)
            $display("FAIL and_done_edge got %0d want 32", de);
        else
            passed++;
        total++;
        if (ok !== 1'b1)
            $display("FAIL and_vec_sequence got ok=%b want 1", ok);
        else
            passed++;
        total++;
        if ({io.pass, io.err_cnt, io.first_err_vec, io.vec} !== {1'b1, 4'd0, 3'd0, 3'd7})
            $display("FAIL and_result got pass=%b err=%0d first=%0d vec=%0d want 1/0/0/7",
                     io.pass, io.err_cnt, io.first_err_vec, io.vec);
        else
            passed++;
    endtask

    task automatic test_stuck0();
        int de;
        bit ok;
        mode = 1;
        pulse_start();
        wait_done(0, de, ok);
        total++;
        if ({io.done, io.pass, io.err_cnt, io.first_err_vec} !== {1'b1, 1'b0, 4'd1, 3'd7})
            $display("FAIL stuck0 got done=%b pass=%b err=%0d first=%0d want 1/0/1/7",
                     io.done, io.pass, io.err_cnt, io.first_err_vec);
        else
            passed++;
    endtask

    task automatic test_stuck1();
        int de;
        bit ok;
        mode = 2;
        pulse_start();
        wait_done(0, de, ok);
        total++;
        if ({io.done, io.pass, io.err_cnt, io.first_err_vec} !== {1'b1, 1'b0, 4'd7, 3'd0})
            $display("FAIL stuck1 got done=%b pass=%b err=%0d first=%0d want 1/0/7/0",
                     io.done, io.pass, io.err_cnt, io.first_err_vec);
        else
            passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({io.done, io.err_cnt, io.vec} !== {1'b1, 4'd7, 3'd7})
            $display("FAIL done_hold got done=%b err=%0d vec=%0d want 1/7/7",
                     io.done, io.err_cnt, io.vec);
        else
            passed++;
    endtask

    task automatic test_restart_from_done();
        int de;
        bit ok;
        mode = 0;
        pulse_start();
        total++;
        if ({io.done, io.pass, io.busy, io.err_cnt, io.first_err_vec} !== {1'b0, 1'b0, 1'b1, 4'd0, 3'd0})
            $display("FAIL restart_clear got done=%b pass=%b busy=%b err=%0d first=%0d want 0/0/1/0/0",
                     io.done, io.pass, io.busy, io.err_cnt, io.first_err_vec);
        else
            passed++;
        wait_done(0, de, ok);
        total++;
        if (de !== 32 || io.pass !== 1'b1 || ok !== 1'b1)
            $display("FAIL restart_run got edge=%0d pass=%b ok=%b want 32/1/1",
                     de, io.pass, ok);
        else
            passed++;
    endtask

    task automatic test_start_ignored();
        int de;
        bit ok;
        mode = 0;
        pulse_start();
        wait_done(13, de, ok);
        total++;
        if (de !== 32 || ok !== 1'b1)
            $display("FAIL ignore_start_timing got edge=%0d ok=%b want 32/1",
                     de, ok);
        else
            passed++;
        total++;
        if ({io.pass, io.err_cnt, io.first_err_vec} !== {1'b1, 4'd0, 3'd0})
            $display("FAIL ignore_start_result got pass=%b err=%0d first=%0d want 1/0/0",
                     io.pass, io.err_cnt, io.first_err_vec);
        else
            passed++;
    endtask

    task automatic test_midrun_reset();
        mode = 2;
        pulse_start();
        repeat (21) @(posedge clk);
        #1;
        total++;
        if (io.vec !== 3'd5 || io.err_cnt !== 4'd5)
            $display("FAIL pre_reset got vec=%0d err=%0d want 5/5",
                     io.vec, io.err_cnt);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if ({io.vec, io.busy, io.done, io.pass, io.err_cnt, io.first_err_vec} !== '0)
            $display("FAIL midrun_reset got vec=%0d busy=%b done=%b err=%0d want all 0",
                     io.vec, io.busy, io.done, io.err_cnt);
        else
            passed++;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({io.vec, io.busy, io.done, io.pass, io.err_cnt} !== '0)
            $display("FAIL idle_after_reset got vec=%0d busy=%b done=%b err=%0d want all 0",
                     io.vec, io.busy, io.done, io.err_cnt);
        else
            passed++;
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        mode     = 0;
        rst_n    = 1'b0;
        io.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_and_run();
        test_stuck0();
        test_stuck1();
        test_restart_from_done();
        test_start_ignored();
        test_midrun_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
